branch_issue_scheduler: RTL and testbench
=========================================

// Module: branch_issue_scheduler
// PURPOSE
//  Reservation station and issue scheduler for the combinational branch unit.
//  Buffers dispatched branch ops (Jz/Jnz/Jgt/Jlt) until their operands are ready, capturing them from the CDB.
//  Issues the oldest ready op through a registered issue slot; the branch unit evaluates that slot.
//  Sits between rename/dispatch and the branch unit. The ROB drives flush on mispredict.
// PARAMETERS
//  DEPTH   4   entries held, excluding the issue slot (2..8)
//  DATA_W  16  operand/target width
//  TAG_W   4   ROB index width; also the CDB tag width
// PORTS
//  clk           in   1       clock, rising edge
//  rst_n         in   1       asynchronous active-low reset
//  flush         in   1       drop all entries and the issue slot
//  disp_valid    in   1       dispatch request
//  disp_ready    out  1       entry free and no flush (combinational)
//  disp_opcode   in   4       1000 Jz, 1001 Jnz, 1010 Jgt, 1011 Jlt
//  disp_rob      in   TAG_W   ROB index of the branch
//  disp_{t,a,b}_rdy  in  1    operand already valid
//  disp_{t,a,b}_val  in  DATA_W  operand value when rdy
//  disp_{t,a,b}_tag  in  TAG_W   producer ROB tag when not rdy
//  cdb_valid     in   1       result broadcast
//  cdb_tag       in   TAG_W   producer tag
//  cdb_value     in   DATA_W  broadcast value
//  iss_valid     out  1       issue slot occupied (registered)
//  iss_ready     in   1       branch unit consumes the slot this cycle
//  iss_opcode    out  4       registered op fields
//  iss_rob       out  TAG_W
//  iss_vt/va/vb  out  DATA_W  resolved target and operands
//  count         out  clog2(DEPTH+1)  occupied entries, excluding the slot
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - all entry valid bits, iss_valid and count go to 0; iss_* data goes to 0.
//   - disp_ready=1 once rst_n releases.
//  Storage: a compacting queue; entry 0 is the oldest. Per entry: opcode, rob, and per operand {rdy, tag, val}.
//  Dispatch: accepted when disp_valid & disp_ready; disp_ready = (count<DEPTH) & ~flush.
//   - The new entry is appended after the youngest entry.
//   - A non-ready operand whose tag matches cdb_tag while cdb_valid in the same cycle is captured as ready (bypass).
//  Wakeup: every cycle each valid, non-ready operand with tag==cdb_tag & cdb_valid takes rdy=1, val=cdb_value.
//  Select: the lowest-index entry whose t, a and b are all rdy (registered state, not this cycle's CDB).
//  Slot load: when ~iss_valid or iss_ready, the selected entry moves into the slot at the edge.
//   - The queue compacts by one in the same edge; count is updated.
//   - If nothing is selectable, iss_valid falls on a consumed edge.
//  Latency: an op dispatched ready at edge N shows iss_valid after edge N+1.
//   - A CDB wakeup at edge N makes an op issuable at N+1.
//  Hold: while iss_valid & ~iss_ready, the slot and its fields are stable and no entry is removed.
//  Simultaneous events:
//   - dispatch + slot load in one cycle: count unchanged.
//   - The new entry lands at index count-1 after compaction.
//   - The CDB updates entries while they shift, so no wakeup is lost.
//  Full: count==DEPTH drops disp_ready. A same-cycle slot load does NOT raise disp_ready (no combinational path from iss_ready).
//  Opcode: other values are not expected. If dispatched, the entry is still buffered and issued; the branch unit ignores it.
//  Flush: synchronous, highest priority. At the edge it clears all entries, count and iss_valid.
//   - Dispatch is blocked and the CDB is ignored during the flush cycle.
//   - A reset mid-operation acts like a flush, asynchronously.
//  Tag width: ROB tag compares are exact TAG_W-bit compares; there is no tag wrap logic (ROB guarantees uniqueness).
// TESTING
//  1 Reset, then dispatch Jz rob=3, all rdy, va=0
//    -> iss_valid=1 one cycle later with iss_rob=3, iss_va=0; count returns to 0.
//  2 Jgt rob=5, a tag=7 not rdy, b rdy=2; next cycle CDB tag=7 value=9
//    -> issues the cycle after the CDB with va=9, vb=2.
//  3 Fill 4 entries, none ready, then dispatch again
//    -> disp_ready=0, count=4; CDB wakes entry 2 only -> entry 2 issues first, then count=3.
//  4 Entries 0 and 1 both ready, iss_ready=0 for 3 cycles
//    -> slot holds entry 0 stable; after consume, entry 1 issues next cycle.
//  5 Dispatch with a non-ready operand while the CDB broadcasts that same tag
//    -> the operand is captured; issue follows the next edge.
//  6 Flush with 3 entries + valid slot, disp_valid=1
//    -> next cycle count=0, iss_valid=0, dispatch dropped; rst_n low mid-issue clears outputs immediately.

Source files
------------

// File: rtl/branch_issue_scheduler.sv
// Reservation station for the branch unit: a compacting queue of branch ops that
// wake up from the CDB, with the oldest ready op moved into a registered issue slot.
module branch_issue_scheduler #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  parameter int TAG_W  = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              disp_valid,
  output logic              disp_ready,
  input  logic [3:0]        disp_opcode,
  input  logic [TAG_W-1:0]  disp_rob,
  input  logic              disp_t_rdy,
  input  logic [DATA_W-1:0] disp_t_val,
  input  logic [TAG_W-1:0]  disp_t_tag,
  input  logic              disp_a_rdy,
  input  logic [DATA_W-1:0] disp_a_val,
  input  logic [TAG_W-1:0]  disp_a_tag,
  input  logic              disp_b_rdy,
  input  logic [DATA_W-1:0] disp_b_val,
  input  logic [TAG_W-1:0]  disp_b_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_value,
  output logic              iss_valid,
  input  logic              iss_ready,
  output logic [3:0]        iss_opcode,
  output logic [TAG_W-1:0]  iss_rob,
  output logic [DATA_W-1:0] iss_vt,
  output logic [DATA_W-1:0] iss_va,
  output logic [DATA_W-1:0] iss_vb,
  output logic [CW-1:0]     count
);

  // Handshakes: dispatch transfers when disp_valid & disp_ready at a rising edge;
  // the issue slot is consumed when iss_valid & iss_ready at a rising edge, and
  // while iss_valid & ~iss_ready the slot contents are held unchanged.

  typedef struct packed {
    logic [3:0]        opcode;
    logic [TAG_W-1:0]  rob;
    logic              t_rdy;
    logic [TAG_W-1:0]  t_tag;
    logic [DATA_W-1:0] t_val;
    logic              a_rdy;
    logic [TAG_W-1:0]  a_tag;
    logic [DATA_W-1:0] a_val;
    logic              b_rdy;
    logic [TAG_W-1:0]  b_tag;
    logic [DATA_W-1:0] b_val;
  } entry_t;

  entry_t          ent_q [DEPTH];
  entry_t          ent_d [DEPTH];
  entry_t          ent_w [DEPTH];
  entry_t          iss_q, iss_d;
  entry_t          new_e, sel_e;
  logic            iss_valid_q, iss_valid_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   sel_idx, base;
  logic            sel_found, take, load, disp_fire, cdb_hit;

  function automatic entry_t wake(entry_t e, logic hit, logic [TAG_W-1:0] tag,
                                  logic [DATA_W-1:0] val);
    entry_t r;
    r = e;
    if (hit && !r.t_rdy && r.t_tag == tag) begin r.t_rdy = 1'b1; r.t_val = val; end
    if (hit && !r.a_rdy && r.a_tag == tag) begin r.a_rdy = 1'b1; r.a_val = val; end
    if (hit && !r.b_rdy && r.b_tag == tag) begin r.b_rdy = 1'b1; r.b_val = val; end
    return r;
  endfunction

  assign disp_ready = (count_q < CW'(DEPTH)) & ~flush;

  always_comb begin
    disp_fire = disp_valid & disp_ready;
    load      = ~iss_valid_q | iss_ready;
    cdb_hit   = cdb_valid & ~flush;

    new_e.opcode = disp_opcode;
    new_e.rob    = disp_rob;
    new_e.t_rdy  = disp_t_rdy;
    new_e.t_tag  = disp_t_tag;
    new_e.t_val  = disp_t_val;
    new_e.a_rdy  = disp_a_rdy;
    new_e.a_tag  = disp_a_tag;
    new_e.a_val  = disp_a_val;
    new_e.b_rdy  = disp_b_rdy;
    new_e.b_tag  = disp_b_tag;
    new_e.b_val  = disp_b_val;
    new_e        = wake(new_e, cdb_hit, cdb_tag, cdb_value);

    // Select looks at registered readiness only; a same-cycle CDB hit issues next cycle.
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_e     = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (CW'(i) < count_q && ent_q[i].t_rdy && ent_q[i].a_rdy && ent_q[i].b_rdy) begin
        sel_found = 1'b1;
        sel_idx   = CW'(i);
        sel_e     = ent_q[i];
      end
    end
    take = load & sel_found;

    for (int i = 0; i < DEPTH; i++) begin
      ent_w[i] = wake(ent_q[i], cdb_hit, cdb_tag, cdb_value);
    end

    // Compaction shifts the already-woken entries so no broadcast is lost.
    for (int i = 0; i < DEPTH - 1; i++) begin
      ent_d[i] = (take && CW'(i) >= sel_idx) ? ent_w[i+1] : ent_w[i];
    end
    ent_d[DEPTH-1] = ent_w[DEPTH-1];

    base = count_q - CW'(take);
    for (int i = 0; i < DEPTH; i++) begin
      if (disp_fire && CW'(i) == base) ent_d[i] = new_e;
    end
    count_d = base + CW'(disp_fire);

    iss_valid_d = iss_valid_q;
    iss_d       = iss_q;
    if (take) begin
      iss_valid_d = 1'b1;
      iss_d       = sel_e;
    end else if (load) begin
      iss_valid_d = 1'b0;
    end

    if (flush) begin
      count_d     = '0;
      iss_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      iss_valid_q <= 1'b0;
      iss_q       <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      count_q     <= count_d;
      iss_valid_q <= iss_valid_d;
      iss_q       <= iss_d;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

  assign iss_valid  = iss_valid_q;
  assign iss_opcode = iss_q.opcode;
  assign iss_rob    = iss_q.rob;
  assign iss_vt     = iss_q.t_val;
  assign iss_va     = iss_q.a_val;
  assign iss_vb     = iss_q.b_val;
  assign count      = count_q;

endmodule

// File: tb/tb_branch_issue_scheduler.sv
// Bench for branch_issue_scheduler: directed scenarios with literal expectations,
// then random traffic compared every cycle against a queue-level reference model.
module tb_branch_issue_scheduler;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 16;
  localparam int TAG_W  = 4;
  localparam int CW     = $clog2(DEPTH + 1);

  logic              clk, rst_n, flush;
  logic              disp_valid, disp_ready;
  logic [3:0]        disp_opcode;
  logic [TAG_W-1:0]  disp_rob;
  logic              disp_t_rdy, disp_a_rdy, disp_b_rdy;
  logic [DATA_W-1:0] disp_t_val, disp_a_val, disp_b_val;
  logic [TAG_W-1:0]  disp_t_tag, disp_a_tag, disp_b_tag;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_value;
  logic              iss_valid, iss_ready;
  logic [3:0]        iss_opcode;
  logic [TAG_W-1:0]  iss_rob;
  logic [DATA_W-1:0] iss_vt, iss_va, iss_vb;
  logic [CW-1:0]     count;

  branch_issue_scheduler #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_opcode(disp_opcode), .disp_rob(disp_rob),
    .disp_t_rdy(disp_t_rdy), .disp_t_val(disp_t_val), .disp_t_tag(disp_t_tag),
    .disp_a_rdy(disp_a_rdy), .disp_a_val(disp_a_val), .disp_a_tag(disp_a_tag),
    .disp_b_rdy(disp_b_rdy), .disp_b_val(disp_b_val), .disp_b_tag(disp_b_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_opcode(iss_opcode), .iss_rob(iss_rob),
    .iss_vt(iss_vt), .iss_va(iss_va), .iss_vb(iss_vb),
    .count(count)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [3:0]                   op;
    logic [TAG_W-1:0]             rob;
    logic [2:0]                   rdy;
    logic [2:0][TAG_W-1:0]        tag;
    logic [2:0][DATA_W-1:0]       val;
  } op_t;

  op_t              mq[$];
  op_t              mslot;
  bit               mslot_v;
  logic [TAG_W-1:0] exp_q[$];
  int               n_checks, n_fail;
  bit               chk_en;
  bit               m_acc;
  int               m_idx;
  op_t              m_nd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic op_t wake_op(op_t o);
    for (int j = 0; j < 3; j++) begin
      if (cdb_valid && !o.rdy[j] && o.tag[j] == cdb_tag) begin
        o.rdy[j] = 1'b1;
        o.val[j] = cdb_value;
      end
    end
    return o;
  endfunction

  function automatic op_t cur_disp();
    op_t o;
    o.op     = disp_opcode;
    o.rob    = disp_rob;
    o.rdy    = {disp_b_rdy, disp_a_rdy, disp_t_rdy};
    o.tag[0] = disp_t_tag; o.tag[1] = disp_a_tag; o.tag[2] = disp_b_tag;
    o.val[0] = disp_t_val; o.val[1] = disp_a_val; o.val[2] = disp_b_val;
    return o;
  endfunction

  // Reference model: a queue in age order plus one slot.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete(); exp_q.delete();
      mslot_v = 1'b0; mslot = '0;
    end else if (flush) begin
      mq.delete(); exp_q.delete();
      mslot_v = 1'b0;
    end else begin
      m_acc = disp_valid && (mq.size() < DEPTH);
      m_nd  = wake_op(cur_disp());
      if (!mslot_v || iss_ready) begin
        m_idx = -1;
        foreach (mq[k]) if (m_idx < 0 && mq[k].rdy == 3'b111) m_idx = k;
        if (m_idx >= 0) begin
          mslot   = mq[m_idx];
          mslot_v = 1'b1;
          mq.delete(m_idx);
          exp_q.push_back(mslot.rob);
        end else begin
          mslot_v = 1'b0;
        end
      end
      foreach (mq[k]) mq[k] = wake_op(mq[k]);
      if (m_acc) mq.push_back(m_nd);
    end
  end

  // Compare process.
  always @(negedge clk) begin
    if (chk_en) begin
      check("iss_valid", 32'(iss_valid), 32'(mslot_v));
      if (mslot_v) begin
        check("iss_opcode", 32'(iss_opcode), 32'(mslot.op));
        check("iss_rob", 32'(iss_rob), 32'(mslot.rob));
        check("iss_vt", 32'(iss_vt), 32'(mslot.val[0]));
        check("iss_va", 32'(iss_va), 32'(mslot.val[1]));
        check("iss_vb", 32'(iss_vb), 32'(mslot.val[2]));
      end
      check("count", 32'(count), 32'(mq.size()));
      check("disp_ready", 32'(disp_ready), 32'((mq.size() < DEPTH) && !flush));
      if (rst_n && !flush && mslot_v && iss_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL issue_order: slot consumed with empty expected queue at %0t", $time);
        end else begin
          check("issue_order", 32'(iss_rob), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_valid = 1'b0; cdb_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic disp(input logic [3:0] op, input logic [TAG_W-1:0] rob, input logic [2:0] rdy,
                      input logic [TAG_W-1:0] tt, input logic [TAG_W-1:0] ta,
                      input logic [TAG_W-1:0] tb, input logic [DATA_W-1:0] vt,
                      input logic [DATA_W-1:0] va, input logic [DATA_W-1:0] vb);
    disp_valid = 1'b1; disp_opcode = op; disp_rob = rob;
    disp_t_rdy = rdy[0]; disp_a_rdy = rdy[1]; disp_b_rdy = rdy[2];
    disp_t_tag = tt; disp_a_tag = ta; disp_b_tag = tb;
    disp_t_val = vt; disp_a_val = va; disp_b_val = vb;
  endtask

  task automatic cdb(input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] val);
    cdb_valid = 1'b1; cdb_tag = tag; cdb_value = val;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0; n_fail = 0; chk_en = 1'b0;
    rst_n = 1'b1; iss_ready = 1'b0;
    idle();
    disp(4'h8, '0, 3'b000, '0, '0, '0, '0, '0, '0);
    disp_valid = 1'b0;
    cdb_tag = '0; cdb_value = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    check("reset_disp_ready", 32'(disp_ready), 32'd1);
    check("reset_count", 32'(count), 32'd0);
    check("reset_iss_valid", 32'(iss_valid), 32'd0);

    // Ready Jz issues one cycle after dispatch.
    iss_ready = 1'b1;
    disp(4'b1000, 4'd3, 3'b111, '0, '0, '0, 16'h1234, 16'h0000, 16'h0000);
    tick();
    check("t1_count_after_disp", 32'(count), 32'd1);
    check("t1_not_yet_issued", 32'(iss_valid), 32'd0);
    idle(); tick();
    check("t1_iss_valid", 32'(iss_valid), 32'd1);
    check("t1_iss_rob", 32'(iss_rob), 32'd3);
    check("t1_iss_va", 32'(iss_va), 32'd0);
    check("t1_count", 32'(count), 32'd0);
    tick();
    check("t1_drained", 32'(iss_valid), 32'd0);

    // CDB wakeup then issue.
    disp(4'b1010, 4'd5, 3'b101, '0, 4'd7, '0, 16'h0100, 16'h0000, 16'h0002);
    tick();
    idle(); cdb(4'd7, 16'd9); tick();
    check("t2_not_yet", 32'(iss_valid), 32'd0);
    idle(); tick();
    check("t2_iss_valid", 32'(iss_valid), 32'd1);
    check("t2_iss_rob", 32'(iss_rob), 32'd5);
    check("t2_iss_va", 32'(iss_va), 32'd9);
    check("t2_iss_vb", 32'(iss_vb), 32'd2);
    tick();

    // Fill with non-ready ops; wake only the third.
    for (int i = 1; i <= 4; i++) begin
      disp(4'b1001, TAG_W'(i), 3'b101, '0, TAG_W'(8 + i), '0, 16'h0011, 16'h0, 16'h0022);
      tick();
    end
    disp(4'b1000, 4'd6, 3'b111, '0, '0, '0, '0, '0, '0);
    #1;
    check("t3_full_ready", 32'(disp_ready), 32'd0);
    check("t3_full_count", 32'(count), 32'd4);
    tick();
    idle(); cdb(4'd11, 16'h0055); tick();
    idle(); tick();
    check("t3_iss_rob", 32'(iss_rob), 32'd3);
    check("t3_iss_va", 32'(iss_va), 32'h55);
    check("t3_count", 32'(count), 32'd3);
    flush = 1'b1; tick();
    idle(); tick();

    // Hold under back-pressure.
    iss_ready = 1'b0;
    disp(4'b1011, 4'd6, 3'b111, '0, '0, '0, 16'h6, 16'h6, 16'h6); tick();
    disp(4'b1011, 4'd7, 3'b111, '0, '0, '0, 16'h7, 16'h7, 16'h7); tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      check("t4_hold_rob", 32'(iss_rob), 32'd6);
      check("t4_hold_count", 32'(count), 32'd1);
      tick();
    end
    iss_ready = 1'b1; tick();
    check("t4_next_rob", 32'(iss_rob), 32'd7);
    check("t4_next_count", 32'(count), 32'd0);
    tick();
    check("t4_drained", 32'(iss_valid), 32'd0);

    // Dispatch bypass from the CDB.
    disp(4'b1000, 4'd9, 3'b011, '0, '0, 4'd13, 16'h1, 16'h2, 16'h0);
    cdb(4'd13, 16'h0077);
    tick();
    idle();
    check("t5_count", 32'(count), 32'd1);
    tick();
    check("t5_iss_rob", 32'(iss_rob), 32'd9);
    check("t5_iss_vb", 32'(iss_vb), 32'h77);
    tick();

    // Flush with a valid slot and queued entries, then async reset mid-issue.
    iss_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      disp(4'b1000, TAG_W'(i), 3'b111, '0, '0, '0, '0, '0, '0);
      tick();
    end
    check("t6_pre_count", 32'(count), 32'd3);
    check("t6_pre_rob", 32'(iss_rob), 32'd1);
    disp(4'b1000, 4'd5, 3'b111, '0, '0, '0, '0, '0, '0);
    flush = 1'b1;
    #1;
    check("t6_flush_ready", 32'(disp_ready), 32'd0);
    tick();
    idle();
    check("t6_flush_count", 32'(count), 32'd0);
    check("t6_flush_iss", 32'(iss_valid), 32'd0);
    tick();
    check("t6_dropped", 32'(count), 32'd0);
    disp(4'b1001, 4'd2, 3'b111, '0, '0, '0, 16'hAAAA, 16'hBBBB, 16'hCCCC); tick();
    idle(); tick();
    check("t6_issued", 32'(iss_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_iss_valid", 32'(iss_valid), 32'd0);
    check("t6_rst_count", 32'(count), 32'd0);
    check("t6_rst_iss_rob", 32'(iss_rob), 32'd0);
    check("t6_rst_iss_va", 32'(iss_va), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      disp_valid  = ($urandom_range(0, 99) < 60);
      disp_opcode = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'(8 + $urandom_range(0, 3));
      disp_rob    = TAG_W'($urandom);
      disp_t_rdy  = ($urandom_range(0, 99) < 60);
      disp_a_rdy  = ($urandom_range(0, 99) < 50);
      disp_b_rdy  = ($urandom_range(0, 99) < 50);
      disp_t_tag  = TAG_W'($urandom);
      disp_a_tag  = TAG_W'($urandom);
      disp_b_tag  = TAG_W'($urandom);
      disp_t_val  = DATA_W'($urandom);
      disp_a_val  = DATA_W'($urandom);
      disp_b_val  = DATA_W'($urandom);
      cdb_valid   = ($urandom_range(0, 99) < 60);
      cdb_tag     = TAG_W'($urandom);
      cdb_value   = DATA_W'($urandom);
      iss_ready   = ($urandom_range(0, 99) < 65);
      flush       = ($urandom_range(0, 99) < 2);
      tick();
    end
    idle(); iss_ready = 1'b1;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
